// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM state
// encodings and default latencies. Accumulate codes are decoded only when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// EX-stage multiply/divide unit owning HI/LO; results are computed at start and
// released after a fixed latency. Optional madd/msub family under MDU_MADD_EN.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic [3:0]  mdu_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [31:0] resHi_q, resLo_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  mdu_op_e     op;
  logic        launch;
  logic [3:0]  cycles;
  logic [31:0] shHi_d, shLo_d;
  logic [63:0] prodS, prodU;
  logic [31:0] aMag, bMag, bSafe, uSafe, qMag, rMag, quotS, remS;

  assign op = mdu_op_e'(mdu_op);

  // Signed divide works on magnitudes so INT_MIN / -1 wraps to 0x80000000 naturally.
  always_comb begin
    prodS  = {{32{A1[31]}}, A1} * {{32{A2[31]}}, A2};
    prodU  = {32'b0, A1} * {32'b0, A2};
    aMag   = A1[31] ? -A1 : A1;
    bMag   = A2[31] ? -A2 : A2;
    bSafe  = (A2 == 32'd0) ? 32'd1 : bMag;
    uSafe  = (A2 == 32'd0) ? 32'd1 : A2;
    qMag   = aMag / bSafe;
    rMag   = aMag % bSafe;
    quotS  = (A1[31] ^ A2[31]) ? -qMag : qMag;
    remS   = A1[31] ? -rMag : rMag;
    launch = 1'b0;
    cycles = 4'd0;
    shHi_d = hi_q;
    shLo_d = lo_q;
    if (start && state_q == ST_IDLE) begin
      case (op)
        MDU_MULT: begin
          launch = 1'b1;
          cycles = 4'(MULT_CYCLES);
          {shHi_d, shLo_d} = prodS;
        end
        MDU_MULTU: begin
          launch = 1'b1;
          cycles = 4'(MULT_CYCLES);
          {shHi_d, shLo_d} = prodU;
        end
        MDU_DIV: begin
          launch = 1'b1;
          cycles = 4'(DIV_CYCLES);
          if (A2 != 32'd0) begin
            shHi_d = remS;
            shLo_d = quotS;
          end
        end
        MDU_DIVU: begin
          launch = 1'b1;
          cycles = 4'(DIV_CYCLES);
          if (A2 != 32'd0) begin
            shHi_d = A1 % uSafe;
            shLo_d = A1 / uSafe;
          end
        end
`ifdef MDU_MADD_EN
        MDU_MADD: begin
          launch = 1'b1;
          cycles = 4'(MULT_CYCLES);
          {shHi_d, shLo_d} = {hi_q, lo_q} + prodS;
        end
        MDU_MADDU: begin
          launch = 1'b1;
          cycles = 4'(MULT_CYCLES);
          {shHi_d, shLo_d} = {hi_q, lo_q} + prodU;
        end
        MDU_MSUB: begin
          launch = 1'b1;
          cycles = 4'(MULT_CYCLES);
          {shHi_d, shLo_d} = {hi_q, lo_q} - prodS;
        end
        MDU_MSUBU: begin
          launch = 1'b1;
          cycles = 4'(MULT_CYCLES);
          {shHi_d, shLo_d} = {hi_q, lo_q} - prodU;
        end
`endif
        default: ;
      endcase
    end
  end

  // A start seen while BUSY is dropped; only the counter and shadows drive completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      resHi_q <= 32'd0;
      resLo_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            resHi_q <= shHi_d;
            resLo_q <= shLo_d;
            cnt_q   <= cycles;
            busy_q  <= 1'b1;
            state_q <= ST_BUSY;
          end else if (start && op == MDU_MTHI) begin
            hi_q <= A1;
          end else if (start && op == MDU_MTLO) begin
            lo_q <= A1;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            hi_q    <= resHi_q;
            lo_q    <= resLo_q;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized operations compared
// against a longint-arithmetic reference model of HI/LO and latency.
module tb_mdu;

  logic        clk;
  logic        reset_n;
  logic [31:0] A1, A2;
  logic [3:0]  mdu_op;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo;

  int          assertCount;
  int          failCount;
  logic [31:0] modelHi, modelLo;

  mdu dut (
    .clk    (clk),
    .reset_n(reset_n),
    .A1     (A1),
    .A2     (A2),
    .mdu_op (mdu_op),
    .start  (start),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of one instruction, from plain arithmetic
  task automatic refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hiIn, input logic [31:0] loIn,
                          output logic [31:0] hiOut, output logic [31:0] loOut,
                          output int lat);
    longint          sa, sb, sq, sr, sp;
    longint unsigned ua, ub, up, acc;
    logic [63:0]     res;
    bit              maddEn;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sp = sa * sb;
    up = ua * ub;
    acc = {hiIn, loIn};
    hiOut = hiIn;
    loOut = loIn;
    lat = 0;
`ifdef MDU_MADD_EN
    maddEn = 1'b1;
`else
    maddEn = 1'b0;
`endif
    case (op)
      4'd1: begin res = sp; {hiOut, loOut} = res; lat = 5; end
      4'd2: begin res = up; {hiOut, loOut} = res; lat = 5; end
      4'd3: begin
        lat = 10;
        if (b != 0) begin
          sq = sa / sb;
          sr = sa % sb;
          loOut = sq[31:0];
          hiOut = sr[31:0];
        end
      end
      4'd4: begin
        lat = 10;
        if (b != 0) begin
          up = ua / ub;
          loOut = up[31:0];
          up = ua % ub;
          hiOut = up[31:0];
        end
      end
      4'd5: hiOut = a;
      4'd6: loOut = a;
      4'd7, 4'd8, 4'd9, 4'd10: begin
        if (maddEn) begin
          lat = 5;
          if (op == 4'd7)      res = acc + longint'(sp);
          else if (op == 4'd8) res = acc + up;
          else if (op == 4'd9) res = acc - longint'(sp);
          else                 res = acc - up;
          {hiOut, loOut} = res;
        end
      end
      default: ;
    endcase
  endtask

  // Issue one instruction, watch busy, then compare HI/LO with the model.
  // interject=1 fires a stray mult start on the third busy cycle.
  task automatic applyStimulus(input string tag, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b, input bit interject);
    logic [31:0] expHi, expLo;
    int lat, cnt;
    refModel(op, a, b, modelHi, modelLo, expHi, expLo, lat);
    @(negedge clk);
    start = 1'b1; mdu_op = op; A1 = a; A2 = b;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      checkOutput({tag, " hi-hold"}, hi, modelHi);
      checkOutput({tag, " lo-hold"}, lo, modelLo);
      cnt++;
      if (interject && cnt == 3) begin
        start = 1'b1; mdu_op = 4'd1; A1 = $urandom; A2 = $urandom;
      end else begin
        start = 1'b0; mdu_op = 4'd0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({tag, " busy-cycles"}, 32'(cnt), 32'(lat));
    checkOutput({tag, " hi"}, hi, expHi);
    checkOutput({tag, " lo"}, lo, expLo);
    modelHi = expHi;
    modelLo = expLo;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global-timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    assertCount = 0;
    failCount   = 0;
    modelHi = 32'd0;
    modelLo = 32'd0;
    start = 1'b0; mdu_op = 4'd0; A1 = 32'd0; A2 = 32'd0;

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    reset_n = 1'b1;

    applyStimulus("mult -2*3",  4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    applyStimulus("multu",      4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    applyStimulus("div -7/2",   4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus("divu 7/0",   4'd4, 32'd7, 32'd0, 1'b0);
    applyStimulus("div 7/0",    4'd3, 32'd7, 32'd0, 1'b0);
    applyStimulus("div minneg", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("mthi",       4'd5, 32'h1234_5678, 32'd0, 1'b0);
    applyStimulus("mtlo",       4'd6, 32'h9ABC_DEF0, 32'd0, 1'b0);
    applyStimulus("div 100/-7 interject", 4'd3, 32'd100, 32'hFFFF_FFF9, 1'b1);

    // madd family: effective only when the accumulate datapath is built
    applyStimulus("mthi 0",       4'd5, 32'd0, 32'd0, 1'b0);
    applyStimulus("mtlo ffff",    4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    applyStimulus("madd 1*1",     4'd7, 32'd1, 32'd1, 1'b0);
    applyStimulus("msubu",        4'd10, 32'd3, 32'd5, 1'b0);
    applyStimulus("op none",      4'd0, 32'hDEAD_BEEF, 32'd1, 1'b0);
    applyStimulus("op 13",        4'd13, 32'hDEAD_BEEF, 32'd1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 11));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      applyStimulus($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 1'b0);
    end

    // Reset on the fourth busy cycle of a mult discards the pending result
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd1; A1 = 32'd1234; A2 = 32'd5678;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset busy", {31'b0, busy}, 32'd0);
    checkOutput("midreset hi", hi, 32'd0);
    checkOutput("midreset lo", lo, 32'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("postreset busy", {31'b0, busy}, 32'd0);
    checkOutput("postreset lo", lo, 32'd0);
    modelHi = 32'd0;
    modelLo = 32'd0;

    // Reset and start on the same edge: reset wins
    start = 1'b1; mdu_op = 4'd5; A1 = 32'hCAFE_F00D; reset_n = 1'b0;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0; reset_n = 1'b1;
    checkOutput("reset+start hi", hi, 32'd0);
    checkOutput("reset+start busy", {31'b0, busy}, 32'd0);

    applyStimulus("final multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline, sitting beside the ALU and consuming the same forwarded rs/rt operands (A1/A2). It executes mult/multu/div/divu with fixed multi-cycle latency, owns the architectural HI/LO registers, and raises `busy` so the hazard unit stalls later HI/LO-dependent instructions in ID. mfhi/mflo are served by the EX result mux reading the `hi`/`lo` outputs.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu (and madd-family when enabled); legal range 1..15.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range 1..15.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `A1` in 32: forwarded rs value.
- `A2` in 32: forwarded rt value.
- `mdu_op` in 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7–10 under `MDU_MADD_EN`.
- `start` in 1: operation valid this cycle; asserted by EX for one cycle per instruction, never while stalled.
- `busy` out 1: a multi-cycle operation is in flight.
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.

## Operation
- States: IDLE, BUSY. 4-bit down-counter `cnt`; 32-bit shadow registers `res_hi`, `res_lo`.
- IDLE + `start` + op 1–4 (7–10 if enabled): compute result from A1/A2 this cycle, latch into shadows, load `cnt` with MULT_CYCLES or DIV_CYCLES, go BUSY.
- BUSY: decrement `cnt` each cycle; when `cnt`==1, copy shadows into `hi`/`lo`, go IDLE.
- mult: {hi,lo} = signed 64-bit A1×A2. multu: unsigned 64-bit product.
- div: lo = signed quotient (truncating toward zero), hi = remainder with A1's sign. divu: unsigned quotient/remainder.
- Divide by zero (A2==0): operation still takes DIV_CYCLES with `busy`; `hi`/`lo` retain their prior values.
- div with A1=0x80000000, A2=0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- mthi/mtlo (IDLE + `start`): write A1 to `hi`/`lo` at the next edge; no busy cycles.
- `start` while BUSY: ignored entirely (hazard unit guarantees it never happens; the unit must not corrupt the in-flight result).
- `start` with op 0 or an unenabled code: no effect.

## Timing
- Reset: `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0, shadows 0.
- `start` sampled at edge E: `busy` high in the N cycles after E; `hi`/`lo` updated at edge E+N; `busy` low and new values visible from E+N onward.
- `busy` is a registered output; the hazard unit ORs it with `start` to stall the instruction immediately following.
- mthi/mtlo at edge E: new value visible after E.
- Reset mid-operation (`reset_n`=0 at any edge while BUSY): pending result discarded, all outputs return to reset values at that edge.
- Reset and `start` at the same edge: reset wins.

## Configuration
- `MDU_MADD_EN` defined: ops 7 madd ({hi,lo} += signed A1×A2), 8 maddu (unsigned +=), 9 msub (signed −=), 10 msubu (unsigned −=); 64-bit wrap-around, MULT_CYCLES latency; accumulation uses the {hi,lo} value at `start`.
- Undefined: codes 7–10 behave as op 0; no accumulate datapath synthesized.

## Structure
- Shared defines package/header: `mdu_op` codes (MDU_NONE…MDU_MSUBU), state encodings, MULT_CYCLES/DIV_CYCLES defaults, alongside the existing ALU op codes.
- Single module; no sub-module. Product/quotient computed with behavioural `*`, `/`, `%` at `start`; the counter only models latency.

## Test plan
- Reset: hold `reset_n`=0 two cycles -> `busy`=0, `hi`=`lo`=0.
- mult A1=0xFFFFFFFE (−2), A2=3 -> `busy` high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div A1=0xFFFFFFF9 (−7), A2=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 -> busy 10 cycles, hi/lo unchanged.
- mthi A1=0x12345678 then mtlo A1=0x9ABCDEF0 back-to-back -> hi/lo hold those values after each edge, `busy` never rises.
- `start` mult during BUSY of a div, then `reset_n`=0 on cycle 4 of a mult -> first start ignored, div result correct; after reset `busy`=0, hi=lo=0.
- With `MDU_MADD_EN`: hi=0, lo=0xFFFFFFFF, madd A1=1, A2=1 -> hi=0x00000001, lo=0x00000000; without the macro same stimulus -> no change, `busy` stays 0.
